// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from explicit AND/OR/XOR terms.
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic prop;
    logic gen;
    logic prop_c;

    assign prop   = a_i ^ b_i;
    assign gen    = a_i & b_i;
    assign prop_c = prop & cin_i;
    assign sum_o  = prop ^ cin_i;
    assign cout_o = gen | prop_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB first.
// Handshake: start is accepted only in IDLE; done pulses one cycle with sum/carryout/overflow valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum;
    logic fa_cout;

    serial_fa_cell u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .cin_i (c_q),
        .sum_o (fa_sum),
        .cout_o(fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = carryin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d = {fa_sum, s_q[WIDTH-1:1]};
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                c_d = fa_cout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // c_q here is the carry into the MSB, needed for signed overflow.
                    sum_d   = {fa_sum, s_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = c_q ^ fa_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
    logic [1:0]   dbg_state;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] held;
    int           total;
    int           bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {overflow, carryout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {ovf, full};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done after a start driven at the previous negedge; checks outputs hold until then.
    task automatic wait_result(input string tag, input bit keep_start, input bit scramble);
        logic [W+1:0] e;
        bit           seen;
        int           lat;
        int           busy_n;
        seen   = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!keep_start) start = 1'b0;
                if (scramble) begin
                    a = 8'h11;
                    b = 8'h22;
                end
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                check($sformatf("%s hold", tag), {overflow, carryout, sum}, held);
            end
        end
        check($sformatf("%s done_seen", tag), seen, 1);
        check($sformatf("%s latency", tag), lat, W + 1);
        check($sformatf("%s busy_cycles", tag), busy_n, W + 1);
        check($sformatf("%s queue", tag), exp_q.size(), 1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s sum", tag), sum, e[W-1:0]);
            check($sformatf("%s carryout", tag), carryout, e[W]);
            check($sformatf("%s overflow", tag), overflow, e[W+1]);
            held = e;
        end
        @(negedge clk);
        check($sformatf("%s pulse_end", tag), {busy, done}, 2'b00);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input bit scramble);
        a       = x;
        b       = y;
        carryin = ci;
        start   = 1'b1;
        exp_q.push_back(model(x, y, ci));
        wait_result(tag, 1'b0, scramble);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        held    = '0;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy_done", {busy, done}, 2'b00);
        check("reset result", {overflow, carryout, sum}, '0);
        check("reset state", dbg_state, 2'd0);

        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        do_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("7f_plus_1", 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op("a5_5a_ci", 8'hA5, 8'h5A, 1'b1, 1'b1);

        // start held high through RUN and DONE: one operation per IDLE visit.
        a       = 8'h80;
        b       = 8'h80;
        carryin = 1'b0;
        start   = 1'b1;
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        wait_result("busy_first", 1'b1, 1'b0);
        a = 8'h33;
        b = 8'h44;
        exp_q.push_back(model(8'h33, 8'h44, 1'b0));
        wait_result("busy_second", 1'b0, 1'b0);

        // Reset in the middle of an operation discards the partial result.
        do_op("pre_reset", 8'h50, 8'h05, 1'b0, 1'b0);
        a       = 8'h0F;
        b       = 8'h01;
        carryin = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        held  = '0;
        check("midrst state", dbg_state, 2'd0);
        check("midrst busy_done", {busy, done}, 2'b00);
        check("midrst result", {overflow, carryout, sum}, '0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst no_done", {busy, done}, 2'b00);
        end
        do_op("post_reset", 8'h0F, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("rand%0d", i), W'($urandom_range(0, 255)),
                  W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell and a registered carry.
- Takes two WIDTH-bit operands plus carry-in on a start handshake, then processes one bit per clock, LSB first.
- Presents the registered sum, carry-out and signed overflow with a one-cycle done pulse.
- Acts as the sequencing stage wrapped around the team's 1-bit full adder: it feeds the cell one bit pair per cycle and consumes its sum and carry outputs.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- carryin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- carryout  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset:
  - Clock edge with reset=1 forces state=IDLE.
  - busy, done, sum, carryout and overflow all go to 0.
  - Internal shift registers, carry flop and counter all clear to 0.
  - Reset overrides every other input, including mid-RUN; a partial result is discarded and never appears on sum.
- State IDLE:
  - busy=0, done=0.
  - Edge with start=1: load A/B shift regs from a/b, carry flop from carryin, bit counter=0; next state RUN.
  - Edge with start=0: stay in IDLE.
- State RUN:
  - Each edge: the FA cell sees A[0], B[0] and the carry flop.
  - Its sum bit shifts into the MSB of the sum shift register (register shifts right).
  - A and B shift right; carry flop takes the cell's carry out; counter increments.
  - On the edge where counter==WIDTH-1:
    - sum output takes the completed shift-register value.
    - carryout takes the cell's carry out.
    - overflow takes the carry flop value (carry into MSB) XOR the cell's carry out.
    - Next state DONE.
- State DONE:
  - done=1 and busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Timing:
  - Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH (WIDTH+1 edges per operation).
  - Throughput: one add per WIDTH+2 cycles.
- Boundary rules:
  - start while busy (RUN or DONE) is ignored, never queued. The earliest new acceptance is the edge after done deasserts.
  - sum, carryout and overflow change only on the RUN->DONE edge or on reset. Between operations they hold the last result; intermediate shift values are never visible.
  - a, b and carryin may change freely after the accepted edge without affecting the result.
  - Width rule: {carryout,sum} == a + b + carryin, computed modulo 2^(WIDTH+1).
  - Counter width: clog2(WIDTH) bits; no wrap occurs within a legal operation.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH constant.
- One natural sub-module: serial_fa_cell, a purely combinational 1-bit full adder (a, b, cin -> sum, cout) built structurally from AND/OR/XOR gates, consistent with the team's existing gate-level adders.
- All sequencing, shift registers and the carry flop live in serial_adder.

Test Plan:
- Reset, then a=0x00, b=0x00, carryin=0, start pulse:
  - done pulses exactly 9 cycles after the start edge (the cycle after edge WIDTH).
  - sum=0x00, carryout=0, overflow=0.
  - busy high for 9 cycles.
- a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1, overflow=0.
- a=0x7F, b=0x01, carryin=0 -> sum=0x80, carryout=0, overflow=1.
- a=0xA5, b=0x5A, carryin=1 -> sum=0x00, carryout=1, overflow=0.
  - Operands are changed to 0x11/0x22 one cycle after acceptance; the result must be unaffected.
- Busy handling, starting from a=0x80, b=0x80 -> sum=0x00, carryout=1, overflow=1:
  - start held high continuously: only one operation runs per IDLE visit.
  - start asserted during RUN and in the DONE cycle is ignored.
  - A new start one cycle after done is accepted.
  - sum holds 0x00 until the next done.
- Reset mid-operation:
  - After a completed add leaves sum=0x55, start 0x0F+0x01 and assert reset at RUN cycle 4.
  - Next cycle: state IDLE, sum=0x00, carryout=0, overflow=0, busy=0, and no done pulse.
  - A fresh start then yields sum=0x10, carryout=0.
